// File: rtl/sd_block_read_ctrl.sv
// rtl/sd_block_read_ctrl.sv - SD CMD17 single-block read sequencer over a byte-wide SPI engine
// Frames CMD17, polls R1 and the data token, streams 512 payload bytes, and drops the CRC.
module sd_block_read_ctrl #(
  parameter int R1_POLLS    = 8,
  parameter int TOKEN_POLLS = 4096
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic [31:0] lba_i,
  input  logic        sdhc_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        error_o,
  output logic [2:0]  err_code_o,
  output logic [7:0]  r1_o,
  output logic [7:0]  data_out_o,
  output logic        data_valid_o,
  output logic [8:0]  data_index_o,
  output logic        spi_cs_n_o,
  output logic [7:0]  spi_tx_byte_o,
  output logic        spi_start_o,
  input  logic        spi_ready_i,
  input  logic [7:0]  spi_rx_byte_i
);

  localparam logic [12:0] R1_LAST  = 13'(R1_POLLS - 1);
  localparam logic [12:0] TOK_LAST = 13'(TOKEN_POLLS - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_PRE, S_CMD, S_R1, S_TOKEN, S_DATA, S_CRC, S_POST, S_FIN
  } state_e;

  typedef enum logic [1:0] {
    PH_ISSUE, PH_WAIT_LOW, PH_WAIT_HIGH
  } phase_e;

  state_e      state_q;
  phase_e      phase_q;
  logic [12:0] cnt_q;
  logic [31:0] addr_q;
  logic        busy_q;
  logic        done_q;
  logic        error_q;
  logic [2:0]  err_code_q;
  logic [7:0]  r1_q;
  logic [7:0]  data_out_q;
  logic        data_valid_q;
  logic [8:0]  data_index_q;
  logic        cs_n_q;
  logic [7:0]  spi_tx_byte_q;
  logic        spi_start_q;

  logic        xfer_done_d;
  logic [7:0]  tx_byte_d;

  // A transfer is complete on the first cycle ready returns high after it dropped.
  assign xfer_done_d = (phase_q == PH_WAIT_HIGH) && spi_ready_i;

  always_comb begin
    tx_byte_d = 8'hFF;
    if (state_q == S_CMD) begin
      case (cnt_q[2:0])
        3'd0:    tx_byte_d = 8'h51;
        3'd1:    tx_byte_d = addr_q[31:24];
        3'd2:    tx_byte_d = addr_q[23:16];
        3'd3:    tx_byte_d = addr_q[15:8];
        3'd4:    tx_byte_d = addr_q[7:0];
        default: tx_byte_d = 8'hFF;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q       <= S_IDLE;
      phase_q       <= PH_ISSUE;
      cnt_q         <= '0;
      addr_q        <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
      err_code_q    <= 3'd0;
      r1_q          <= 8'hFF;
      data_out_q    <= 8'h00;
      data_valid_q  <= 1'b0;
      data_index_q  <= 9'd0;
      cs_n_q        <= 1'b1;
      spi_tx_byte_q <= 8'hFF;
      spi_start_q   <= 1'b0;
    end else begin
      spi_start_q  <= 1'b0;
      done_q       <= 1'b0;
      data_valid_q <= 1'b0;

      if (state_q != S_IDLE && state_q != S_FIN) begin
        case (phase_q)
          PH_ISSUE: begin
            if (spi_ready_i) begin
              spi_start_q   <= 1'b1;
              spi_tx_byte_q <= tx_byte_d;
              phase_q       <= PH_WAIT_LOW;
            end
          end
          PH_WAIT_LOW:  if (!spi_ready_i) phase_q <= PH_WAIT_HIGH;
          PH_WAIT_HIGH: if (spi_ready_i) phase_q <= PH_ISSUE;
          default:      phase_q <= PH_ISSUE;
        endcase
      end

      case (state_q)
        S_IDLE: begin
          // A start coinciding with done belongs to the finishing command's consumer; drop it.
          if (start_i && !done_q) begin
            addr_q     <= sdhc_i ? lba_i : {lba_i[22:0], 9'd0};
            busy_q     <= 1'b1;
            cs_n_q     <= 1'b0;
            error_q    <= 1'b0;
            err_code_q <= 3'd0;
            r1_q       <= 8'hFF;
            phase_q    <= PH_ISSUE;
            cnt_q      <= '0;
            state_q    <= S_PRE;
          end
        end
        S_PRE: begin
          if (xfer_done_d) begin
            cnt_q   <= '0;
            state_q <= S_CMD;
          end
        end
        S_CMD: begin
          if (xfer_done_d) begin
            if (cnt_q == 13'd5) begin
              cnt_q   <= '0;
              state_q <= S_R1;
            end else begin
              cnt_q <= cnt_q + 13'd1;
            end
          end
        end
        S_R1: begin
          if (xfer_done_d) begin
            if (spi_rx_byte_i == 8'hFF) begin
              if (cnt_q == R1_LAST) begin
                err_code_q <= 3'd1;
                cs_n_q     <= 1'b1;
                state_q    <= S_POST;
              end else begin
                cnt_q <= cnt_q + 13'd1;
              end
            end else begin
              r1_q <= spi_rx_byte_i;
              if (spi_rx_byte_i == 8'h00) begin
                cnt_q   <= '0;
                state_q <= S_TOKEN;
              end else begin
                err_code_q <= 3'd2;
                cs_n_q     <= 1'b1;
                state_q    <= S_POST;
              end
            end
          end
        end
        S_TOKEN: begin
          if (xfer_done_d) begin
            if (spi_rx_byte_i == 8'hFE) begin
              cnt_q   <= '0;
              state_q <= S_DATA;
            end else if (spi_rx_byte_i == 8'hFF) begin
              if (cnt_q == TOK_LAST) begin
                err_code_q <= 3'd3;
                cs_n_q     <= 1'b1;
                state_q    <= S_POST;
              end else begin
                cnt_q <= cnt_q + 13'd1;
              end
            end else begin
              err_code_q <= 3'd4;
              cs_n_q     <= 1'b1;
              state_q    <= S_POST;
            end
          end
        end
        S_DATA: begin
          if (xfer_done_d) begin
            data_out_q   <= spi_rx_byte_i;
            data_valid_q <= 1'b1;
            data_index_q <= cnt_q[8:0];
            if (cnt_q == 13'd511) begin
              cnt_q   <= '0;
              state_q <= S_CRC;
            end else begin
              cnt_q <= cnt_q + 13'd1;
            end
          end
        end
        S_CRC: begin
          if (xfer_done_d) begin
            if (cnt_q == 13'd1) begin
              cs_n_q  <= 1'b1;
              state_q <= S_POST;
            end else begin
              cnt_q <= cnt_q + 13'd1;
            end
          end
        end
        S_POST: begin
          if (xfer_done_d) state_q <= S_FIN;
        end
        S_FIN: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          error_q <= (err_code_q != 3'd0);
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign error_o       = error_q;
  assign err_code_o    = err_code_q;
  assign r1_o          = r1_q;
  assign data_out_o    = data_out_q;
  assign data_valid_o  = data_valid_q;
  assign data_index_o  = data_index_q;
  assign spi_cs_n_o    = cs_n_q;
  assign spi_tx_byte_o = spi_tx_byte_q;
  assign spi_start_o   = spi_start_q;

endmodule

// File: tb/tb_sd_block_read_ctrl.sv
// tb/tb_sd_block_read_ctrl.sv - bench for sd_block_read_ctrl with a scripted SPI engine/card
// Table of read scenarios plus hand sequences for reset behaviour.
module tb_sd_block_read_ctrl;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        sdhc = 1'b1;
  logic [31:0] lba = '0;
  logic        busy, done, error, data_valid, spi_cs_n, spi_start;
  logic [2:0]  err_code;
  logic [7:0]  r1, data_out, spi_tx_byte;
  logic [8:0]  data_index;
  logic        spi_ready = 1'b1;
  logic [7:0]  spi_rx_byte = 8'hFF;

  sd_block_read_ctrl #(.R1_POLLS(8), .TOKEN_POLLS(4096)) dut (
    .clk_i(clk), .reset_i(reset), .start_i(start), .lba_i(lba), .sdhc_i(sdhc),
    .busy_o(busy), .done_o(done), .error_o(error), .err_code_o(err_code), .r1_o(r1),
    .data_out_o(data_out), .data_valid_o(data_valid), .data_index_o(data_index),
    .spi_cs_n_o(spi_cs_n), .spi_tx_byte_o(spi_tx_byte), .spi_start_o(spi_start),
    .spi_ready_i(spi_ready), .spi_rx_byte_i(spi_rx_byte)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] pat(input int i);
    return 8'((i * 7 + 3) & 255);
  endfunction

  // Card/engine model: MISO bytes come from a script, 0xFF once it runs out.
  logic [7:0] miso_mem [0:8191];
  int script_base = 0;
  int script_len = 0;
  int eng_idx = 0;
  int eng_left = 0;

  always @(posedge clk) begin
    if (spi_ready) begin
      if (spi_start) begin
        spi_ready <= 1'b0;
        eng_left  <= 2;
      end
    end else if (eng_left > 1) begin
      eng_left <= eng_left - 1;
    end else begin
      spi_ready <= 1'b1;
      if (eng_idx - script_base < script_len) spi_rx_byte <= miso_mem[eng_idx - script_base];
      else spi_rx_byte <= 8'hFF;
      eng_idx <= eng_idx + 1;
    end
  end

  logic [7:0] tx_log [0:16383];
  logic       cs_log [0:16383];
  int log_cnt = 0;
  int b2b_cnt = 0;
  int nvalid = 0;
  int nvalid_base = 0;
  int dmis = 0;
  logic prev_start = 1'b0;

  always @(negedge clk) begin
    prev_start <= spi_start;
    if (spi_start && prev_start) b2b_cnt <= b2b_cnt + 1;
    if (spi_start) begin
      tx_log[log_cnt & 16383] <= spi_tx_byte;
      cs_log[log_cnt & 16383] <= spi_cs_n;
      log_cnt <= log_cnt + 1;
    end
    if (data_valid) begin
      if (data_index !== 9'(nvalid - nvalid_base) || data_out !== pat(nvalid - nvalid_base))
        dmis <= dmis + 1;
      nvalid <= nvalid + 1;
    end
  end

  typedef struct {
    string       name;
    logic        sdhc;
    logic [31:0] lba;
    int          r1_polls;
    logic [7:0]  r1_val;
    int          tok_polls;
    logic [7:0]  tok_val;
    logic        exp_err;
    logic [2:0]  exp_code;
    logic [7:0]  exp_r1;
    logic [31:0] exp_addr;
    int          exp_data;
    int          exp_xfers;
  } vec_t;

  vec_t vecs [8];

  task automatic push_miso(input logic [7:0] b);
    miso_mem[script_len] = b;
    script_len++;
  endtask

  task automatic run_vec(input vec_t v);
    int lb, b2b0, dm0, cyc, n, txbad, csbad;
    logic [7:0] expb;
    logic got_done;
    script_len = 0;
    for (int i = 0; i < 7; i++) push_miso(8'hFF);
    for (int i = 0; i < v.r1_polls; i++) push_miso(8'hFF);
    push_miso(v.r1_val);
    if (v.r1_val == 8'h00) begin
      for (int i = 0; i < v.tok_polls; i++) push_miso(8'hFF);
      push_miso(v.tok_val);
      if (v.tok_val == 8'hFE) begin
        for (int i = 0; i < 512; i++) push_miso(pat(i));
        push_miso(8'hAB);
        push_miso(8'hCD);
      end
    end
    script_base = eng_idx;
    lb = log_cnt;
    b2b0 = b2b_cnt;
    dm0 = dmis;
    nvalid_base = nvalid;

    start = 1'b1; sdhc = v.sdhc; lba = v.lba;
    @(negedge clk);
    start = 1'b0;
    chk({v.name, " busy_after_start"}, busy, 1);
    @(negedge clk);
    @(negedge clk);
    start = 1'b1; sdhc = 1'b1; lba = 32'hDEADBEEF;
    @(negedge clk);
    start = 1'b0;

    got_done = 1'b0;
    cyc = 0;
    while (!got_done && cyc < 40000) begin
      @(negedge clk);
      cyc++;
      if (done) got_done = 1'b1;
    end
    chk({v.name, " done_seen"}, got_done, 1);
    chk({v.name, " error"}, error, v.exp_err);
    chk({v.name, " err_code"}, err_code, v.exp_code);
    chk({v.name, " r1"}, r1, v.exp_r1);
    chk({v.name, " busy_at_done"}, busy, 0);
    chk({v.name, " cs_n_at_done"}, spi_cs_n, 1);

    start = 1'b1; lba = 32'h5;
    @(negedge clk);
    start = 1'b0;
    chk({v.name, " start_at_done_ignored"}, busy, 0);
    chk({v.name, " done_one_cycle"}, done, 0);

    chk({v.name, " data_count"}, nvalid - nvalid_base, v.exp_data);
    chk({v.name, " data_content"}, dmis - dm0, 0);
    if (v.exp_data == 512) chk({v.name, " data_index_hold"}, data_index, 9'd511);
    n = log_cnt - lb;
    chk({v.name, " xfers"}, n, v.exp_xfers);
    chk({v.name, " no_b2b_start"}, b2b_cnt - b2b0, 0);
    txbad = 0;
    csbad = 0;
    for (int i = 0; i < n; i++) begin
      case (i)
        1: expb = 8'h51;
        2: expb = v.exp_addr[31:24];
        3: expb = v.exp_addr[23:16];
        4: expb = v.exp_addr[15:8];
        5: expb = v.exp_addr[7:0];
        default: expb = 8'hFF;
      endcase
      if (tx_log[(lb + i) & 16383] !== expb) txbad++;
      if (cs_log[(lb + i) & 16383] !== ((i == n - 1) ? 1'b1 : 1'b0)) csbad++;
    end
    chk({v.name, " tx_bytes"}, txbad, 0);
    chk({v.name, " cs_n_pattern"}, csbad, 0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " done"}, done, 0);
    chk({tag, " error"}, error, 0);
    chk({tag, " err_code"}, err_code, 0);
    chk({tag, " r1"}, r1, 8'hFF);
    chk({tag, " data_valid"}, data_valid, 0);
    chk({tag, " data_index"}, data_index, 0);
    chk({tag, " cs_n"}, spi_cs_n, 1);
    chk({tag, " spi_start"}, spi_start, 0);
    chk({tag, " spi_tx_byte"}, spi_tx_byte, 8'hFF);
  endtask

  initial begin
    int cyc;
    logic hit;
    //          name          sdhc lba           r1p r1     tokp  tok    err code r1     addr          data xfers
    vecs[0] = '{"basic",      1, 32'h00000012,  2, 8'h00,    3, 8'hFE, 0, 3'd0, 8'h00, 32'h00000012, 512,  529};
    vecs[1] = '{"byteaddr",   0, 32'h00000003,  0, 8'h00,    0, 8'hFE, 0, 3'd0, 8'h00, 32'h00000600, 512,  524};
    vecs[2] = '{"r1_timeout", 0, 32'h00912345,  8, 8'hFF,    0, 8'hFF, 1, 3'd1, 8'hFF, 32'h22468A00,   0,   16};
    vecs[3] = '{"r1_last",    1, 32'hA1B2C3D4,  7, 8'h00,    0, 8'hFE, 0, 3'd0, 8'h00, 32'hA1B2C3D4, 512,  531};
    vecs[4] = '{"r1_err",     1, 32'h00000007,  0, 8'h04,    0, 8'hFF, 1, 3'd2, 8'h04, 32'h00000007,   0,    9};
    vecs[5] = '{"tok_err",    1, 32'h00000100,  0, 8'h00,  100, 8'h09, 1, 3'd4, 8'h00, 32'h00000100,   0,  110};
    vecs[6] = '{"tok_timeout",1, 32'h00000200,  0, 8'h00, 4096, 8'hFF, 1, 3'd3, 8'h00, 32'h00000200,   0, 4105};
    vecs[7] = '{"tok_last",   1, 32'h00000300,  0, 8'h00, 4095, 8'hFE, 0, 3'd0, 8'h00, 32'h00000300, 512, 4619};

    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    reset = 1'b0;
    @(negedge clk);

    for (int k = 0; k < 8; k++) run_vec(vecs[k]);

    // Reset in the middle of the payload, then a clean full read.
    script_len = 0;
    for (int i = 0; i < 9; i++) push_miso(8'hFF);
    push_miso(8'h00);
    push_miso(8'hFE);
    for (int i = 0; i < 512; i++) push_miso(pat(i));
    script_base = eng_idx;
    nvalid_base = nvalid;
    start = 1'b1; sdhc = 1'b1; lba = 32'h42;
    @(negedge clk);
    start = 1'b0;
    hit = 1'b0;
    cyc = 0;
    while (!hit && cyc < 10000) begin
      @(negedge clk);
      cyc++;
      if (data_valid && data_index == 9'd200) hit = 1'b1;
    end
    chk("midreset reached_index_200", hit, 1);
    reset = 1'b1;
    @(negedge clk);
    chk_reset_vals("midreset");
    reset = 1'b0;
    cyc = 0;
    while (!spi_ready && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk("midreset engine_idle", spi_ready, 1);
    nvalid_base = nvalid;
    @(negedge clk);
    run_vec(vecs[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
